// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared types and helpers for the data-cache responder.
//   state_e    : controller states (IDLE, RD_MISS, RD_DONE, WR_BUSY, WR_DONE)
//   WORD_W     : data word width
//   addr_tag   : tag field of a byte address (bits above index and byte offset)
//   addr_index : index field of a byte address (bits just above the byte offset)
// The helpers work on a 64-bit widened address so that any ADDR_W up to 64
// can use them; callers cast the result down to the field width they need.
package dcache_pkg;

    localparam int WORD_W     = 32;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MISS = 3'd1,
        RD_DONE = 3'd2,
        WR_BUSY = 3'd3,
        WR_DONE = 3'd4
    } state_e;

    function automatic logic [MAX_ADDR_W-1:0] addr_tag(
        input logic [MAX_ADDR_W-1:0] a,
        input int                    index_bits
    );
        return a >> (index_bits + 2);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_index(
        input logic [MAX_ADDR_W-1:0] a,
        input int                    index_bits
    );
        return (a >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array
// Direct-mapped line storage: one valid bit, tag and data word per line.
//   clk, rst_n            : clock, async active-low reset (clears valid bits only)
//   rd_index_i, rd_tag_i  : combinational lookup address
//   hit_o, rd_data_o      : lookup result (valid and tag match) and line data
//   we_i, wr_index_i,
//   wr_tag_i, wr_data_i   : single synchronous write port; marks the line valid
module dcache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [TAG_W-1:0]      rd_tag_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Valid bits: cleared by reset, set by any line write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {DEPTH{1'b0}};
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data storage: contents are meaningless while valid is clear, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder
// Direct-mapped, write-through, no-write-allocate data cache controller for a
// single-cycle MIPS datapath.
//   MemRead/MemWrite/addr/wdata : datapath request (held until completion)
//   rdata/MemHit                : load data, valid when MemHit=1
//   MemReadReady/MemReadDone    : read-miss fill in progress / one-cycle completion
//   MemWriteReady/MemWriteDone  : write-through in progress / one-cycle completion
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ack : backing memory port, req held until ack
// Status outputs are decoded combinationally from the state register plus the
// IDLE lookup so that a read hit completes in the request cycle.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              MemHit,
    output logic              MemReadReady,
    output logic              MemReadDone,
    output logic              MemWriteReady,
    output logic              MemWriteDone,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   fill_q, fill_d;
    logic [TAG_W-1:0]    tag_s;
    logic [INDEX_BITS-1:0] index_s;
    logic                hit_s;
    logic [WORD_W-1:0]   line_data_s;
    logic                arr_we_s;
    logic [WORD_W-1:0]   arr_wdata_s;

    assign tag_s   = TAG_W'(addr_tag(MAX_ADDR_W'(addr), INDEX_BITS));
    assign index_s = INDEX_BITS'(addr_index(MAX_ADDR_W'(addr), INDEX_BITS));

    // addr is held stable for the whole transaction, so the same index/tag
    // serves both the IDLE lookup and the fill/write-hit update.
    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (WORD_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index_i (index_s),
        .rd_tag_i   (tag_s),
        .hit_o      (hit_s),
        .rd_data_o  (line_data_s),
        .we_i       (arr_we_s),
        .wr_index_i (index_s),
        .wr_tag_i   (tag_s),
        .wr_data_i  (arr_wdata_s)
    );

    // State and fill-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fill_q  <= {WORD_W{1'b0}};
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic; a request dropped mid-transaction still completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    state_d = WR_BUSY;
                end else if (MemRead && !hit_s) begin
                    state_d = RD_MISS;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    state_d = RD_DONE;
                end else begin
                    state_d = RD_MISS;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_BUSY: begin
                if (mem_ack) begin
                    state_d = WR_DONE;
                end else begin
                    state_d = WR_BUSY;
                end
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line updates: write hit on the IDLE edge that launches the store,
    // fill on the acked edge of a read miss. Write misses never allocate.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_wdata_s = wdata;
        fill_d      = fill_q;
        if ((state_q == IDLE) && MemWrite && hit_s) begin
            arr_we_s    = 1'b1;
            arr_wdata_s = wdata;
        end else if ((state_q == RD_MISS) && mem_ack) begin
            arr_we_s    = 1'b1;
            arr_wdata_s = mem_rdata;
            fill_d      = mem_rdata;
        end else begin
            arr_we_s    = 1'b0;
        end
    end

    // Output decode.
    always_comb begin
        rdata         = {WORD_W{1'b0}};
        MemHit        = 1'b0;
        MemReadReady  = 1'b0;
        MemReadDone   = 1'b0;
        MemWriteReady = 1'b0;
        MemWriteDone  = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = {ADDR_W{1'b0}};
        mem_wdata     = {WORD_W{1'b0}};
        case (state_q)
            IDLE: begin
                // A simultaneous write wins, so a hit is only reported for a pure read.
                if (MemRead && !MemWrite && hit_s) begin
                    MemHit = 1'b1;
                    rdata  = line_data_s;
                end else begin
                    MemHit = 1'b0;
                end
            end
            RD_MISS: begin
                MemReadReady = 1'b1;
                mem_req      = 1'b1;
                mem_we       = 1'b0;
                mem_addr     = {addr[ADDR_W-1:2], 2'b00};
            end
            RD_DONE: begin
                MemHit      = 1'b1;
                MemReadDone = 1'b1;
                rdata       = fill_q;
            end
            WR_BUSY: begin
                MemWriteReady = 1'b1;
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {addr[ADDR_W-1:2], 2'b00};
                mem_wdata     = wdata;
            end
            WR_DONE: begin
                MemWriteDone = 1'b1;
            end
            default: begin
                MemHit = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboarded bench for dcache_responder: directed scenarios followed by
// randomized reads/writes over a small aliasing address pool.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wdata, rdata;
    logic        MemHit, MemReadReady, MemReadDone, MemWriteReady, MemWriteDone;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .MemHit        (MemHit),
        .MemReadReady  (MemReadReady),
        .MemReadDone   (MemReadDone),
        .MemWriteReady (MemWriteReady),
        .MemWriteDone  (MemWriteDone),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: backing memory by word address, and which word address
    // each cache index currently holds. Write-through keeps cached data equal
    // to backing data, so expected load data is always the backing word.
    logic [31:0] bk       [logic [31:0]];
    logic [31:0] resident [int];

    int          ack_delay = 0;
    bit          spurious  = 1'b0;
    logic [31:0] exp_maddr  = 32'h0;
    logic [31:0] exp_mwdata = 32'h0;
    bit          exp_mwe    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            chk("rd_ready_done_excl", 32'(MemReadReady & MemReadDone), 32'h0);
            chk("wr_ready_done_excl", 32'(MemWriteReady & MemWriteDone), 32'h0);
            if (MemHit || MemWriteDone) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_response", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_kind_is_write", 32'(MemWriteDone), 32'(e.is_wr));
                    if (!e.is_wr) chk("rdata", rdata, e.data);
                end
            end
        end
    end

    // Backing memory responder with programmable ack delay.
    initial begin
        int wc;
        wc = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_ack) begin
                mem_ack = 1'b0;
                chk("req_drop_after_ack", 32'(mem_req), 32'h0);
            end else if (spurious) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                spurious  = 1'b0;
            end else if (!mem_req) begin
                wc = 0;
            end else if (wc < ack_delay) begin
                wc++;
            end else begin
                chk("mem_we", 32'(mem_we), 32'(exp_mwe));
                chk("mem_addr", mem_addr, exp_maddr);
                if (exp_mwe) begin
                    chk("mem_wdata", mem_wdata, exp_mwdata);
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = bk.exists(exp_maddr) ? bk[exp_maddr] : 32'h0;
                end
                mem_ack = 1'b1;
                wc = 0;
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input bit hold);
        logic [31:0] wa;
        int          idx;
        bit          hit;
        int          n;
        wa  = a & 32'hFFFF_FFFC;
        idx = int'((a >> 2) & 32'h3F);
        hit = resident.exists(idx) && (resident[idx] == wa);
        if (!bk.exists(wa)) bk[wa] = $urandom;
        exp_maddr  = wa;
        exp_mwe    = 1'b0;
        exp_mwdata = 32'h0;
        sb_q.push_back('{1'b0, bk[wa]});
        @(posedge clk); #1;
        addr = a;
        MemRead = 1'b1;
        @(negedge clk);
        if (hit) begin
            chk("rd_hit_mhit", 32'(MemHit), 32'h1);
            chk("rd_hit_ready", 32'(MemReadReady), 32'h0);
            chk("rd_hit_done", 32'(MemReadDone), 32'h0);
            chk("rd_hit_req", 32'(mem_req), 32'h0);
        end else begin
            chk("rd_miss_mhit0", 32'(MemHit), 32'h0);
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (MemReadDone) break;
                chk("rd_miss_ready", 32'(MemReadReady), 32'h1);
                chk("rd_miss_mhit", 32'(MemHit), 32'h0);
                if (n >= 20) begin
                    chk("rd_miss_timeout", 32'h0, 32'h1);
                    break;
                end
            end
            chk("rd_miss_latency", 32'(n), 32'(2 + ack_delay));
            chk("rd_done_ready", 32'(MemReadReady), 32'h0);
            resident[idx] = wa;
        end
        if (hold) begin
            sb_q.push_back('{1'b0, bk[wa]});
            @(posedge clk);
            @(negedge clk);
            chk("rd_hold_mhit", 32'(MemHit), 32'h1);
            chk("rd_hold_req", 32'(mem_req), 32'h0);
        end
        @(posedge clk); #1;
        MemRead = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
        logic [31:0] wa;
        int          n;
        wa = a & 32'hFFFF_FFFC;
        bk[wa]     = d;
        exp_maddr  = wa;
        exp_mwe    = 1'b1;
        exp_mwdata = d;
        sb_q.push_back('{1'b1, d});
        @(posedge clk); #1;
        addr = a;
        wdata = d;
        MemWrite = 1'b1;
        MemRead = both;
        @(negedge clk);
        chk("wr_idle_mhit", 32'(MemHit), 32'h0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (MemWriteDone) break;
            chk("wr_busy_ready", 32'(MemWriteReady), 32'h1);
            chk("wr_busy_mhit", 32'(MemHit), 32'h0);
            if (n >= 20) begin
                chk("wr_timeout", 32'h0, 32'h1);
                break;
            end
        end
        chk("wr_latency", 32'(n), 32'(2 + ack_delay));
        chk("wr_done_ready", 32'(MemWriteReady), 32'h0);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        MemRead = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        rst_n = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_status", {26'h0, MemHit, MemReadReady, MemReadDone,
                           MemWriteReady, MemWriteDone, mem_req}, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        bk[32'h40] = 32'hDEAD_BEEF;
        ack_delay = 0;
        do_read(32'h40, 1'b1);
        do_read(32'h40, 1'b0);
        ack_delay = 3;
        do_write(32'h40, 32'h1234_5678, 1'b0);
        ack_delay = 0;
        do_read(32'h40, 1'b0);
        ack_delay = 1;
        do_write(32'h1040, 32'hCAFE_F00D, 1'b0);
        do_read(32'h40, 1'b0);
        do_read(32'h1040, 1'b0);
        do_write(32'h80, 32'hA5A5_5A5A, 1'b1);

        // Stray ack while idle must be ignored.
        @(posedge clk); #1;
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        ack_delay = 0;
        do_read(32'h1040, 1'b0);

        // Randomized traffic over 4 tags x 8 indices with random byte offsets.
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do_write(ra, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                do_read(ra, 1'($urandom_range(0, 1)));
            end
        end

        // Make 0x40 resident, then reset in the middle of a read miss.
        ack_delay = 0;
        do_read(32'h40, 1'b0);
        ack_delay = 10;
        @(posedge clk); #1;
        addr = 32'h3000;
        MemRead = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_status", {27'h0, MemHit, MemReadReady, MemReadDone,
                              MemWriteReady, MemWriteDone}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        MemRead = 1'b0;
        resident.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        do_read(32'h40, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-memory responder for the single-cycle MIPS datapath: a direct-mapped, write-through, no-write-allocate data cache controller.
- Receives MemRead/MemWrite requests from the datapath and returns data.
- Generates the MemHit, MemReadReady/MemReadDone and MemWriteReady/MemWriteDone status that the next-PC logic uses to stall or advance the PC.
- Misses and all writes go to a backing memory through a req/ack port.

Parameters:
- INDEX_BITS, 6, cache index width; 2**INDEX_BITS one-word lines.
- ADDR_W, 32, byte address width; tag = addr[ADDR_W-1:INDEX_BITS+2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request; held stable until completion.
- MemWrite  in  1  store request; held stable until completion.
- addr  in  ADDR_W  byte address; word aligned, bits [1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data; valid when MemHit=1.
- MemHit  out  1  load data valid this cycle.
- MemReadReady  out  1  read miss fill in progress (PC stalls).
- MemReadDone  out  1  fill complete, one-cycle pulse.
- MemWriteReady  out  1  write-through in progress (PC stalls).
- MemWriteDone  out  1  write complete, one-cycle pulse.
- mem_req  out  1  backing memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  word-aligned backing address.
- mem_wdata  out  32  backing write data.
- mem_rdata  in  32  backing read data; valid with mem_ack on a read.
- mem_ack  in  1  one-cycle completion; ignored when mem_req=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits cleared.
  - All status outputs, mem_req and mem_we are 0; rdata, mem_addr and mem_wdata are 0.
  - Reset mid-transaction abandons it immediately, with no done pulse.
- State machine: IDLE, RD_MISS, RD_DONE, WR_BUSY, WR_DONE. States are registered; status outputs are decoded combinationally from state plus the IDLE lookup.
- IDLE, request priority:
  - MemWrite has priority over MemRead if both are high.
  - MemWrite=1: go to WR_BUSY. If the line is valid and the tag matches, update the line data in the same edge (write hit). On a miss the line is untouched (no allocate).
  - MemRead=1 with a valid, tag-matching line: MemHit=1 and rdata=line data in the same cycle, with Ready=Done=0. This is a zero-latency hit; stay in IDLE.
  - MemRead=1 with a miss: MemHit=0; go to RD_MISS.
  - No request: all status 0.
- RD_MISS:
  - Outputs: MemReadReady=1, mem_req=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - On mem_ack: write the line (valid=1, tag, data=mem_rdata), latch mem_rdata into fill_q, go to RD_DONE.
- RD_DONE (exactly 1 cycle):
  - Outputs: MemHit=1, MemReadDone=1, MemReadReady=0, rdata=fill_q.
  - Always returns to IDLE. A MemRead still high next cycle is a new request and now hits.
- WR_BUSY:
  - Outputs: MemWriteReady=1, mem_req=1, mem_we=1, mem_addr, mem_wdata=wdata.
  - On mem_ack go to WR_DONE.
- WR_DONE (exactly 1 cycle):
  - Outputs: MemWriteDone=1, MemWriteReady=0. Return to IDLE.
- Invariants:
  - Ready and Done are never both 1.
  - mem_req deasserts the cycle after mem_ack.
  - The minimum miss latency is 2 cycles after the request (ack the cycle after req asserted), then 1 done cycle.
- Boundaries:
  - A request dropped mid-miss/write is a protocol error; the block completes the transaction anyway.
  - mem_ack while in IDLE is ignored.
  - Index wraps naturally: aliasing addresses evict by tag replacement.

Decomposition:
- Package dcache_pkg: the state enum type (IDLE, RD_MISS, RD_DONE, WR_BUSY, WR_DONE), WORD_W=32, and a function for tag/index extraction from an address.
- One sub-module, dcache_array: valid/tag/data storage with async-reset valid bits, combinational read port (hit, data), and a single synchronous write port.
- The FSM and output decode live in dcache_responder.

Test Plan:
- Reset then MemRead addr=0x0000_0040:
  - MemHit=0, MemReadReady=1, mem_req=1, mem_addr=0x40.
  - mem_ack with mem_rdata=0xDEADBEEF next cycle → next cycle MemHit=1, MemReadDone=1, rdata=0xDEADBEEF.
  - Then back in IDLE with MemRead still high: MemHit=1 immediately with no mem_req.
- Read hit on 0x40 after fill: MemHit=1, rdata=0xDEADBEEF, Ready=Done=0 in the same cycle as the request; mem_req stays 0.
- MemWrite addr=0x40 wdata=0x12345678:
  - MemWriteReady=1, mem_we=1, mem_wdata=0x12345678.
  - Ack after 3 cycles → one-cycle MemWriteDone=1.
  - Subsequent read of 0x40 hits with 0x12345678.
- Write miss to 0x1040 (same index as 0x40, different tag): backing write occurs; a later read of 0x40 still hits with its old data, and a read of 0x1040 misses.
- MemRead=MemWrite=1 at addr 0x80: write path taken (mem_we=1, MemWriteReady=1), MemHit=0.
- rst_n pulsed low during RD_MISS: mem_req=0 and all status 0 asynchronously; read of the prior hit address 0x40 afterwards misses (valid cleared).
